tanh_arg_cond: RTL and testbench

TANH_ARG_COND -- requirements
Module: tanh_arg_cond

---
 rtl/tanh_arg_cond.sv | 61 ++++++
 tb/tb_tanh_arg_cond.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tanh_arg_cond.sv
// tanh_arg_cond: folds a signed argument into the tanh core's [0, ZMAX] domain and restores the sign on its result
module tanh_arg_cond #(
   parameter int                 word_SZ = 18,
   parameter int                 frac_SZ = 16,
   parameter logic [word_SZ-1:0] ZMAX    = word_SZ'(1) << frac_SZ,
   parameter int                 LAT     = 33
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [word_SZ-1:0] in_data,
   output logic [word_SZ-1:0] core_angle,
   input  logic [word_SZ-1:0] core_result,
   output logic               out_valid,
   output logic [word_SZ-1:0] out_data,
   output logic               out_clip,
   output logic [15:0]        clip_count
);
   localparam logic [word_SZ-1:0] MOST_NEG = {1'b1, {(word_SZ-1){1'b0}}};
   logic [word_SZ-1:0] mag, angle_q, angle_d, data_q, data_d;
   logic               clip, valid_q, clip_q, clip_d;
   // {valid, sign, clip}: [0] travels alongside core_angle, [LAT] meets its core_result
   logic [LAT:0][2:0]  sb_q, sb_d;
   logic [15:0]        cnt_q, cnt_d;
   // Input stage: fold to magnitude, clip to ZMAX, tag a sideband entry, count clips
   always_comb begin
      mag     = in_data[word_SZ-1] ? -in_data : in_data;
      clip    = (in_data == MOST_NEG) || (mag > ZMAX);
      angle_d = in_valid ? (clip ? ZMAX : mag) : '0;
      sb_d    = {sb_q[LAT-1:0], {in_valid, in_valid & in_data[word_SZ-1], in_valid & clip}};
      cnt_d   = (in_valid && clip && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
   end
   // Output stage: restore the sign when the leaving entry is valid, otherwise hold
   always_comb begin
      data_d = sb_q[LAT][2] ? (sb_q[LAT][1] ? -core_result : core_result) : data_q;
      clip_d = sb_q[LAT][2] ? sb_q[LAT][0] : clip_q;
   end
   // State registers; the core itself is unreset, its stale output is masked by sideband valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         angle_q <= '0;
         sb_q    <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         clip_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         angle_q <= angle_d;
         sb_q    <= sb_d;
         valid_q <= sb_q[LAT][2];
         data_q  <= data_d;
         clip_q  <= clip_d;
         cnt_q   <= cnt_d;
      end
   end
   assign core_angle = angle_q;
   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign out_clip   = clip_q;
   assign clip_count = cnt_q;
endmodule

// File: tb/tb_tanh_arg_cond.sv
// tb_tanh_arg_cond: scoreboard bench with a behavioural LAT-cycle tanh core
module tb_tanh_arg_cond;
   localparam int W = 18;
   localparam int LAT = 33;
   typedef struct {logic [W-1:0] d; logic c; int t;} exp_t;
   logic clk = 0, rst_n = 1, in_valid = 0;
   logic [W-1:0] in_data = '0, core_angle, core_result, out_data;
   logic out_valid, out_clip;
   logic [15:0] clip_count;
   logic [W-1:0] pipe [LAT];
   exp_t q[$];
   exp_t e;
   logic [W-1:0] seen[$];
   int cyc = 0, checks = 0, errors = 0;
   tanh_arg_cond dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .core_angle(core_angle), .core_result(core_result), .out_valid(out_valid),
      .out_data(out_data), .out_clip(out_clip), .clip_count(clip_count));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [W-1:0] tanh_m(input logic [W-1:0] a);
      if (a == 18'h08000) return 18'h0764A;
      if (a == 18'h10000) return 18'h0C2F7;
      return W'((32'(a) * 3) >> 2);
   endfunction
   always @(posedge clk) begin
      pipe[0] <= tanh_m(core_angle);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign core_result = pipe[LAT-1];
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", n, a, x, cyc);
      end
   endtask
   function automatic logic [W:0] model(input logic [W-1:0] x);
      logic [W-1:0] m, r;
      logic c;
      m = x[W-1] ? -x : x;
      c = (x == 18'h20000) || (m > 18'h10000);
      r = tanh_m(c ? 18'h10000 : m);
      return {c, x[W-1] ? -r : r};
   endfunction
   task automatic drive(input logic [W-1:0] x, input logic [W-1:0] d, input logic c);
      exp_t n;
      in_valid = 1;
      in_data = x;
      n.d = d; n.c = c; n.t = cyc + LAT + 2;
      q.push_back(n);
   endtask
   task automatic drive_m(input logic [W-1:0] x);
      logic [W:0] r;
      r = model(x);
      drive(x, r[W-1:0], r[W]);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 0;
      end
   endtask
   task automatic reset_pulse();
      @(negedge clk);
      rst_n = 0;
      in_valid = 0;
      #1;
      chk("rst_core_angle", core_angle, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_clip", out_clip, 0);
      chk("rst_clip_count", clip_count, 0);
      q.delete();
   endtask
   always @(negedge clk) if (out_valid) begin
      if (q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_out_valid: got data %h with nothing pending (cyc %0d)", out_data, cyc);
      end else begin
         e = q.pop_front();
         chk("out_data", out_data, e.d);
         chk("out_clip", out_clip, e.c);
         chk("out_cycle", cyc, e.t);
         seen.push_back(out_data);
      end
   end
   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      #1 rst_n = 0;
      #1;
      chk("rst_core_angle", core_angle, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_clip_count", clip_count, 0);
      idle(2);
      @(negedge clk);
      rst_n = 1;
      // +0.5, -0.5, -1 LSB (result rounds to zero regardless of sign)
      drive(18'h08000, 18'h0764A, 0);
      @(negedge clk); in_valid = 0;
      chk("angle_pos_half", core_angle, 18'h08000);
      @(negedge clk); drive(18'h38000, 18'h389B6, 0);
      @(negedge clk); in_valid = 0;
      chk("angle_neg_half", core_angle, 18'h08000);
      @(negedge clk); drive(18'h3FFFF, 18'h00000, 0);
      @(negedge clk); in_valid = 0;
      chk("angle_neg_lsb", core_angle, 18'h00001);
      // clipped pair, back to back
      @(negedge clk); drive(18'h1C000, 18'h0C2F7, 1);
      @(negedge clk);
      chk("angle_clip_pos", core_angle, 18'h10000);
      drive(18'h20000, 18'h33D09, 1);
      @(negedge clk); in_valid = 0;
      chk("angle_most_neg", core_angle, 18'h10000);
      chk("clip_count_2", clip_count, 2);
      idle(LAT + 5);
      chk("drain_directed", q.size(), 0);
      // symmetric ramp with a 3-slot gap after sample 20
      seen.delete();
      for (int i = 0; i < 40; i++) begin
         if (i == 20) idle(3);
         @(negedge clk);
         drive_m(W'((2 * i - 39) * 32'sh200));
      end
      idle(LAT + 5);
      chk("drain_ramp", q.size(), 0);
      chk("ramp_count", seen.size(), 40);
      if (seen.size() == 40)
         for (int i = 0; i < 20; i++) begin
            logic [W-1:0] neg;
            neg = -seen[i];
            chk("odd_symmetry", seen[39-i], neg);
         end
      // reset in the middle of a stream; sample after release is accepted immediately
      for (int i = 0; i < 10; i++) begin
         if (i == 5) begin
            reset_pulse();
            @(negedge clk);
            rst_n = 1;
         end else @(negedge clk);
         drive_m(W'(i * 32'h5000));
      end
      idle(LAT + 5);
      chk("drain_reset", q.size(), 0);
      // clip counter saturation
      reset_pulse();
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 65545; i++) begin
         @(negedge clk);
         if (i == 65534) chk("clip_count_fffe", clip_count, 16'hFFFE);
         if (i == 65535) chk("clip_count_ffff", clip_count, 16'hFFFF);
         drive_m(i[0] ? 18'h20000 : 18'h1C000);
      end
      @(negedge clk); in_valid = 0;
      chk("clip_count_held", clip_count, 16'hFFFF);
      idle(LAT + 5);
      chk("drain_sat", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
